// File: rtl/vertex_feeder.sv
// Vertex fetch engine: reads four FP32 words per vertex from a synchronous BRAM
// and hands one assembled vertex at a time to the transformation stage.
module vertex_feeder #(
    parameter int ADDR_W  = 12,
    parameter int RAM_LAT = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start_in,
    input  logic [ADDR_W-1:0]      base_addr_in,
    input  logic [ADDR_W-3:0]      num_verts_in,
    output logic                   mem_en_out,
    output logic [ADDR_W-1:0]      mem_addr_out,
    input  logic [31:0]            mem_data_in,
    output logic [3:0][31:0]       pos_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic                   obj_done_out,
    output logic                   busy_out,
    output logic                   done_out
);
    localparam int NW = ADDR_W - 2;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_PRESENT, S_DONE
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_base, r_mem_addr;
    logic [NW-1:0]         r_num, r_i;
    // Stage 0 is the read being issued this cycle; stage RAM_LAT lines up with its data.
    logic [RAM_LAT:0]      r_vld_pipe;
    logic [RAM_LAT:0][1:0] r_k_pipe;
    logic [3:0][31:0]      r_pos;
    logic                  r_valid, r_obj_done, r_busy, r_done;

    logic                  w_last, w_capture;
    logic [1:0]            w_cap_k;
    logic [ADDR_W-1:0]     w_next_vaddr;

    assign w_last       = (r_i == r_num - NW'(1));
    assign w_capture    = r_vld_pipe[RAM_LAT];
    assign w_cap_k      = r_k_pipe[RAM_LAT];
    assign w_next_vaddr = r_base + {r_i + NW'(1), 2'b00};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start_in) w_state_nxt = (num_verts_in == '0) ? S_DONE : S_FETCH;
            S_FETCH:   if (r_k_pipe[0] == 2'd3) w_state_nxt = S_WAIT;
            S_WAIT:    if (w_capture && w_cap_k == 2'd3) w_state_nxt = S_PRESENT;
            S_PRESENT: if (ready_in) w_state_nxt = w_last ? S_DONE : S_FETCH;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_base     <= '0;
            r_num      <= '0;
            r_i        <= '0;
            r_mem_addr <= '0;
            r_vld_pipe <= '0;
            r_k_pipe   <= '0;
            r_pos      <= '0;
            r_valid    <= 1'b0;
            r_obj_done <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            for (int j = 1; j <= RAM_LAT; j++) begin
                r_vld_pipe[j] <= r_vld_pipe[j-1];
                r_k_pipe[j]   <= r_k_pipe[j-1];
            end
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);

            if (w_capture) begin
                r_pos[w_cap_k] <= mem_data_in;
                if (w_cap_k == 2'd3) begin
                    r_valid    <= 1'b1;
                    r_obj_done <= w_last;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_base <= base_addr_in;
                        r_num  <= num_verts_in;
                        r_i    <= '0;
                        if (num_verts_in != '0) begin
                            r_vld_pipe[0] <= 1'b1;
                            r_k_pipe[0]   <= 2'd0;
                            r_mem_addr    <= base_addr_in;
                        end
                    end
                end
                S_FETCH: begin
                    if (r_k_pipe[0] == 2'd3) begin
                        r_vld_pipe[0] <= 1'b0;
                    end else begin
                        r_k_pipe[0] <= r_k_pipe[0] + 2'd1;
                        r_mem_addr  <= r_mem_addr + ADDR_W'(1);
                    end
                end
                S_PRESENT: begin
                    if (ready_in) begin
                        r_valid    <= 1'b0;
                        r_obj_done <= 1'b0;
                        if (!w_last) begin
                            r_i           <= r_i + NW'(1);
                            r_vld_pipe[0] <= 1'b1;
                            r_k_pipe[0]   <= 2'd0;
                            r_mem_addr    <= w_next_vaddr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_en_out   = r_vld_pipe[0];
    assign mem_addr_out = r_mem_addr;
    assign pos_out      = r_pos;
    assign valid_out    = r_valid;
    assign obj_done_out = r_obj_done;
    assign busy_out     = r_busy;
    assign done_out     = r_done;
endmodule

// File: tb/tb_vertex_feeder.sv
// Bench for vertex_feeder: BRAM model with configurable latency, per-object vector table,
// scoreboard of expected vertices checked on every valid/ready transfer.
module tb_vertex_feeder;
    localparam int AW = 12;
    localparam int RL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n = 1'b1, start_in = 1'b0, ready = 1'b1;
    logic            mem_en, valid, objd, busy, done;
    logic [AW-1:0]   base = '0, maddr;
    logic [AW-3:0]   num = '0;
    logic [31:0]     mdata;
    logic [3:0][31:0] pos;

    vertex_feeder #(.ADDR_W(AW), .RAM_LAT(RL)) dut (
        .clk_in(clk), .rst_in(rst_n), .start_in(start_in),
        .base_addr_in(base), .num_verts_in(num),
        .mem_en_out(mem_en), .mem_addr_out(maddr), .mem_data_in(mdata),
        .pos_out(pos), .valid_out(valid), .ready_in(ready),
        .obj_done_out(objd), .busy_out(busy), .done_out(done)
    );

    logic [31:0] mem [0:4095];
    logic [31:0] rd_pipe [RL];
    always @(posedge clk) begin
        rd_pipe[0] <= mem_en ? mem[maddr] : 32'hDEADBEEF;
        for (int j = 1; j < RL; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign mdata = rd_pipe[RL-1];

    typedef struct packed { logic [127:0] pos; logic od; } exp_t;
    typedef struct {
        logic [11:0] base; logic [9:0] num; int stall; bit poke;
        int exp_first; int exp_done;
    } vec_t;

    exp_t        sb[$];
    exp_t        e;
    logic [11:0] exp_addr[$], addr_log[$];
    int n_tests = 0, n_fail = 0, cyc = 0, e0 = 0;
    int first_v = -1, n_en = 0, n_xfer = 0, n_done = 0, stall = 0, st_cnt = 0;
    bit prev_stall = 1'b0;
    logic [127:0] prev_pos = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Holds ready low for `stall` cycles after each valid rises; high otherwise.
    always @(posedge clk) begin
        #1;
        if (valid) begin
            if (st_cnt >= stall) ready = 1'b1;
            else begin ready = 1'b0; st_cnt++; end
        end else begin
            ready = 1'b1;
            st_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (mem_en) begin addr_log.push_back(maddr); n_en++; end
        if (valid && first_v < 0) first_v = cyc;
        if (prev_stall) begin
            chk("stall_valid", valid, 1);
            chk("stall_pos", pos, prev_pos);
        end
        chk("objdone_without_valid", objd & ~valid, 0);
        if (valid && ready) begin
            n_xfer++;
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = sb.pop_front();
                chk("xfer_pos", pos, e.pos);
                chk("xfer_objdone", objd, e.od);
            end
        end
        prev_stall = valid && !ready;
        prev_pos   = pos;
        if (done) n_done++;
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_addr"}, maddr, 0);
        chk({tag, "_pos"}, pos, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_objdone"}, objd, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic run_obj(input vec_t v);
        logic [11:0]  a;
        logic [127:0] p;
        exp_t         x;
        int t, lat;
        bit poked;
        poked = 1'b0;
        stall = v.stall;
        sb.delete(); exp_addr.delete(); addr_log.delete();
        n_en = 0; n_xfer = 0; n_done = 0; first_v = -1;
        for (int i = 0; i < int'(v.num); i++) begin
            for (int k = 0; k < 4; k++) begin
                a = v.base + 12'(4 * i + k);
                exp_addr.push_back(a);
                p[32*k +: 32] = mem[a];
            end
            x.pos = p;
            x.od  = (i == int'(v.num) - 1);
            sb.push_back(x);
        end
        @(posedge clk); #1;
        start_in = 1'b1; base = v.base; num = v.num;
        @(posedge clk); #1;
        e0 = cyc;
        start_in = 1'b0; base = 12'($urandom); num = 10'($urandom);
        chk("busy_after_start", busy, 1);
        t = 0;
        while (!done && t < 3000) begin
            @(posedge clk); #1;
            t++;
            if (v.poke && !poked && valid) begin
                start_in = 1'b1; base = 12'h300; num = 10'd5; poked = 1'b1;
            end else start_in = 1'b0;
        end
        start_in = 1'b0;
        chk("done_timeout", t < 3000, 1);
        chk("done_latency", cyc - e0, v.exp_done);
        lat = (first_v < 0) ? -1 : first_v - e0;
        chk("first_valid_latency", lat, v.exp_first);
        @(posedge clk); #1;
        chk("done_pulse_end", done, 0);
        chk("busy_idle", busy, 0);
        chk("done_count", n_done, 1);
        chk("xfer_count", n_xfer, v.num);
        chk("mem_en_count", n_en, 4 * v.num);
        chk("sb_empty", sb.size(), 0);
        for (int i = 0; i < exp_addr.size(); i++)
            if (i < addr_log.size()) chk("mem_addr", addr_log[i], exp_addr[i]);
    endtask

    vec_t vt[6];
    vec_t vr;

    initial begin
        vt[0] = '{12'h000, 10'd1, 0, 1'b0, 6, 7};
        vt[1] = '{12'h000, 10'd3, 5, 1'b0, 6, 36};
        vt[2] = '{12'h000, 10'd0, 0, 1'b0, -1, 0};
        vt[3] = '{12'hFFC, 10'd2, 0, 1'b0, 6, 14};
        vt[4] = '{12'h200, 10'd2, 3, 1'b1, 6, 20};
        vt[5] = '{12'h123, 10'd4, 1, 1'b0, 6, 32};
        vr    = '{12'h080, 10'd1, 0, 1'b0, 6, 7};

        for (int a = 0; a < 4096; a++) mem[a] = {8'hC3, 12'(a), 12'(a * 7 + 5)};
        mem[0] = 32'h3f800000; mem[1] = 32'h40000000;
        mem[2] = 32'h40400000; mem[3] = 32'h3f800000;

        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_obj(vt[i]);

        // Reset during the second fetch cycle, then restart at a different base.
        sb.delete(); stall = 0;
        @(posedge clk); #1;
        start_in = 1'b1; base = 12'h040; num = 10'd1;
        @(posedge clk); #1;
        start_in = 1'b0;
        @(posedge clk); #1;
        chk("fetch2_addr", maddr, 12'h041);
        rst_n = 1'b0;
        #1 chk_zero("async_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("no_stale_pos", pos, 0);
        chk("no_stale_valid", valid, 0);
        run_obj(vr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
